// File: rtl/ssd_scan_mux.sv
// Four-digit common-anode seven-segment scan driver with per-frame shadow sampling.
// Latency: outputs registered one cycle after the slot counter/index state; no backpressure.
// Optional: define SSD_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module ssd_scan_mux #(
  parameter int c_REFRESH_DIV  = 100000,
  parameter int c_BLANK_CYCLES = 1
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic [3:0] i_Digit_1_val,
  input  logic [3:0] i_Digit_2_val,
  input  logic [3:0] i_Digit_3_val,
  input  logic [3:0] i_Digit_4_val,
  input  logic [3:0] i_DP,
  output logic [3:0] o_Anode,
  output logic [6:0] o_Segment,
  output logic       o_DP
);

  localparam int                 c_CNT_W   = $clog2(c_REFRESH_DIV);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_REFRESH_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_BLANK_K  = c_CNT_W'(c_BLANK_CYCLES);

  logic [c_CNT_W-1:0] slot_cnt;
  logic [1:0]         scan_idx;
  logic [3:0]         shd_d1;
  logic [3:0]         shd_d2;
  logic [3:0]         shd_d3;
  logic [3:0]         shd_d4;
  logic [3:0]         shd_dp;

  logic               frame_start;
  logic               in_blank;
  logic [3:0]         sel_digit;
  logic               lz_blank;
  logic [6:0]         dec_seg;
  logic [3:0]         anode_sel;

  // Hex to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign frame_start = (slot_cnt == '0) && (scan_idx == 2'd0);
  assign in_blank    = (slot_cnt < c_BLANK_K);

  // Select the shadow digit for the active slot; slot 0 is the rightmost digit.
  always_comb begin
    sel_digit = shd_d4;
    anode_sel = 4'b1110;
    case (scan_idx)
      2'd0: begin sel_digit = shd_d4; anode_sel = 4'b1110; end
      2'd1: begin sel_digit = shd_d3; anode_sel = 4'b1101; end
      2'd2: begin sel_digit = shd_d2; anode_sel = 4'b1011; end
      default: begin sel_digit = shd_d1; anode_sel = 4'b0111; end
    endcase
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // A digit is dark when it and every digit to its left are zero; the rightmost always shows.
  always_comb begin
    lz_blank = 1'b0;
    case (scan_idx)
      2'd3: lz_blank = (shd_d1 == 4'd0);
      2'd2: lz_blank = (shd_d1 == 4'd0) && (shd_d2 == 4'd0);
      2'd1: lz_blank = (shd_d1 == 4'd0) && (shd_d2 == 4'd0) && (shd_d3 == 4'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign dec_seg = lz_blank ? 7'b1111111 : hex_to_seg(sel_digit);

  // Slot counter wraps every c_REFRESH_DIV cycles and steps the scan index on wrap.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      slot_cnt <= '0;
      scan_idx <= 2'd0;
    end else if (slot_cnt == c_CNT_LAST) begin
      slot_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Capture all digits together at frame start so a frame never mixes old and new values.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      shd_d1 <= 4'd0;
      shd_d2 <= 4'd0;
      shd_d3 <= 4'd0;
      shd_d4 <= 4'd0;
      shd_dp <= 4'd0;
    end else if (frame_start) begin
      shd_d1 <= i_Digit_1_val;
      shd_d2 <= i_Digit_2_val;
      shd_d3 <= i_Digit_3_val;
      shd_d4 <= i_Digit_4_val;
      shd_dp <= i_DP;
    end
  end

  // Registered display drive; the leading blank cycles of each slot prevent ghosting.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_Anode   <= 4'b1111;
      o_Segment <= 7'b1111111;
      o_DP      <= 1'b1;
    end else if (in_blank) begin
      o_Anode   <= 4'b1111;
      o_Segment <= 7'b1111111;
      o_DP      <= 1'b1;
    end else begin
      o_Anode   <= anode_sel;
      o_Segment <= dec_seg;
      o_DP      <= ~shd_dp[scan_idx];
    end
  end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Self-checking bench for ssd_scan_mux with an 8-cycle slot and 2 blank cycles.
// Expected per-cycle outputs are queued from the frame schedule and compared after each edge.
// All waits are clock edges inside fixed-length loops, so the run always terminates.
module tb_ssd_scan_mux;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic       clk;
  logic       rst_n;
  logic [3:0] d1, d2, d3, d4;
  logic [3:0] dp_in;
  logic [3:0] anode;
  logic [6:0] segment;
  logic       dp_out;

  int checks;
  int failures;
  logic [11:0] exp_q [$];

  ssd_scan_mux #(
    .c_REFRESH_DIV (DIV),
    .c_BLANK_CYCLES(BLANK)
  ) dut (
    .i_CLK        (clk),
    .i_RST_N      (rst_n),
    .i_Digit_1_val(d1),
    .i_Digit_2_val(d2),
    .i_Digit_3_val(d3),
    .i_Digit_4_val(d4),
    .i_DP         (dp_in),
    .o_Anode      (anode),
    .o_Segment    (segment),
    .o_DP         (dp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic lz_dark(input logic [15:0] dig, input int s);
    logic r;
    r = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    if (s == 3) r = (dig[15:12] == 4'd0);
    if (s == 2) r = (dig[15:12] == 4'd0) && (dig[11:8] == 4'd0);
    if (s == 1) r = (dig[15:12] == 4'd0) && (dig[11:8] == 4'd0) && (dig[7:4] == 4'd0);
`endif
    return r;
  endfunction

  // dig packs {digit1, digit2, digit3, digit4}; slot s shows dig[4*s +: 4].
  // Inputs are driven to dig/dp before the frame-start edge, optionally changed to ndig/ndp
  // after edge chg_at; n_edges of the 32 frame edges are checked.
  task automatic run_frame(input string name, input logic [15:0] dig, input logic [3:0] dp,
                           input int n_edges, input int chg_at,
                           input logic [15:0] ndig, input logic [3:0] ndp);
    logic [11:0] exp_v;
    logic [11:0] got_v;
    logic [3:0]  a;
    logic [6:0]  sg;
    {d1, d2, d3, d4} = dig;
    dp_in = dp;
    for (int e = 0; e < n_edges; e++) begin
      int s;
      int k;
      s = e / DIV;
      k = e % DIV;
      if (k < BLANK) begin
        exp_q.push_back({4'b1111, 7'b1111111, 1'b1});
      end else begin
        a = 4'b1111;
        a[s] = 1'b0;
        sg = lz_dark(dig, s) ? 7'b1111111 : SEG_LUT[dig[4*s +: 4]];
        exp_q.push_back({a, sg, ~dp[s]});
      end
    end
    for (int e = 0; e < n_edges; e++) begin
      @(posedge clk);
      #1;
      if (e == chg_at) begin
        {d1, d2, d3, d4} = ndig;
        dp_in = ndp;
      end
      got_v = {anode, segment, dp_out};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s edge=%0d got=%b expected queue entry missing", name, e, got_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          failures++;
          $display("FAIL %s edge=%0d anode/seg/dp got=%b_%b_%b expected=%b_%b_%b",
                   name, e, got_v[11:8], got_v[7:1], got_v[0],
                   exp_v[11:8], exp_v[7:1], exp_v[0]);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {d1, d2, d3, d4} = 16'h1234;
    dp_in = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (anode !== 4'b1111) begin
      failures++;
      $display("FAIL reset_anode got=%b expected=1111", anode);
    end
    checks++;
    if (segment !== 7'b1111111) begin
      failures++;
      $display("FAIL reset_segment got=%b expected=1111111", segment);
    end
    checks++;
    if (dp_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_dp got=%b expected=1", dp_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_frame("basic_1234", 16'h1234, 4'b0000, FRAME, -1, 16'h0, 4'h0);
  endtask

  task automatic test_frame_freeze();
    run_frame("freeze_9999", 16'h9999, 4'b0000, FRAME, 10, 16'h8888, 4'b0000);
    run_frame("freeze_8888", 16'h8888, 4'b0000, FRAME, -1, 16'h0, 4'h0);
  endtask

  task automatic test_hex();
    run_frame("hex_ABCF", 16'hABCF, 4'b0000, FRAME, -1, 16'h0, 4'h0);
  endtask

  task automatic test_dp();
    run_frame("dp_0100", 16'h5678, 4'b0100, FRAME, 3, 16'h5678, 4'b1011);
  endtask

  task automatic test_leading_zero();
    run_frame("lz_0070", 16'h0070, 4'b0000, FRAME, -1, 16'h0, 4'h0);
  endtask

  task automatic test_mid_reset();
    // Stop three cycles into slot 1, where digit 3 is lit on anode 1.
    run_frame("pre_reset", 16'h5678, 4'b0000, DIV + 3, -1, 16'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (anode !== 4'b1111) begin
      failures++;
      $display("FAIL midreset_anode got=%b expected=1111", anode);
    end
    checks++;
    if (segment !== 7'b1111111) begin
      failures++;
      $display("FAIL midreset_segment got=%b expected=1111111", segment);
    end
    checks++;
    if (dp_out !== 1'b1) begin
      failures++;
      $display("FAIL midreset_dp got=%b expected=1", dp_out);
    end
    #2;
    rst_n = 1'b1;
    run_frame("post_reset", 16'h1234, 4'b0001, FRAME, -1, 16'h0, 4'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_frame_freeze();
    test_hex();
    test_dp();
    test_leading_zero();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
